// File: rtl/mac_frame_enc_pkg.sv
// Shared definitions for the egress frame re-assembler.
// Header layout, size limits and FSM state encoding.
package mac_frame_enc_pkg;

    localparam int HDR_DWIDTH_DEF = 128;
    localparam int HDR_BYTES      = 14;
    localparam int HDR_BITS       = HDR_BYTES * 8;
    localparam int SRCPORT_MSB    = 15;
    localparam int SRCPORT_LSB    = 12;
    localparam int ETH_MIN_FRAME  = 60;
    localparam int CNT_W          = 11;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HLOAD,
        ST_HDR,
        ST_BODY,
        ST_PAD,
        ST_DROP
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/mac_frame_enc.sv
// Egress frame re-assembler: header word + body bytes into one byte stream.
// Drops reflected frames and zero-pads frames shorter than MIN_FRAME.
module mac_frame_enc
    import mac_frame_enc_pkg::*;
#(
    parameter int HEADER_DWIDTH = HDR_DWIDTH_DEF,
    parameter int PORT_ID       = 0,
    parameter int MIN_FRAME     = ETH_MIN_FRAME
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [HEADER_DWIDTH-1:0] h_fifo_dout,
    input  logic                     h_fifo_empty,
    output logic                     h_fifo_rden,
    input  logic [7:0]               b_fifo_dout,
    input  logic                     b_fifo_del,
    input  logic                     b_fifo_empty,
    output logic                     b_fifo_rden,
    output logic [7:0]               o_fifo_din,
    output logic                     o_fifo_wren,
    output logic                     o_fifo_del,
    input  logic                     o_fifo_afull,
    output logic [15:0]              frame_cnt,
    output logic [15:0]              drop_cnt
);

    localparam logic [3:0]  PID  = 4'(PORT_ID);
    localparam logic [11:0] MINF = 12'(MIN_FRAME);

    state_t             state;
    logic [HDR_BITS-1:0] hdr;
    logic [CNT_W-1:0]   cnt;
    logic               h_dv;
    logic               b_dv;
    logic               hold_v;
    logic               hold_del;
    logic [7:0]         hold;

    logic               have;
    logic               have_del;
    logic [7:0]         have_byte;
    logic [11:0]        cnt_nx;
    logic               issue;
    logic               unused_bits;

    assign unused_bits = ^h_fifo_dout[SRCPORT_LSB-1:0];

    // A body byte is either arriving from the FIFO now or parked in hold.
    always_comb begin
        have      = b_dv | hold_v;
        have_byte = b_dv ? b_fifo_dout : hold;
        have_del  = b_dv ? b_fifo_del : hold_del;
        cnt_nx    = {1'b0, cnt} + 12'd1;
        issue     = !b_fifo_empty && !b_fifo_rden && !(have && have_del);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            hdr         <= '0;
            cnt         <= '0;
            h_dv        <= 1'b0;
            b_dv        <= 1'b0;
            hold_v      <= 1'b0;
            hold_del    <= 1'b0;
            hold        <= '0;
            h_fifo_rden <= 1'b0;
            b_fifo_rden <= 1'b0;
            o_fifo_din  <= '0;
            o_fifo_wren <= 1'b0;
            o_fifo_del  <= 1'b0;
            frame_cnt   <= '0;
            drop_cnt    <= '0;
        end else begin
            h_fifo_rden <= 1'b0;
            b_fifo_rden <= 1'b0;
            o_fifo_wren <= 1'b0;
            o_fifo_del  <= 1'b0;
            h_dv        <= h_fifo_rden;
            b_dv        <= b_fifo_rden;
            unique case (state)
                ST_IDLE: begin
                    if (!h_fifo_empty) begin
                        h_fifo_rden <= 1'b1;
                        state       <= ST_HLOAD;
                    end
                end
                ST_HLOAD: begin
                    if (h_dv) begin
                        hdr <= h_fifo_dout[HEADER_DWIDTH-1 -: HDR_BITS];
                        cnt <= '0;
                        if (h_fifo_dout[SRCPORT_MSB:SRCPORT_LSB] == PID)
                            state <= ST_DROP;
                        else
                            state <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (!o_fifo_afull) begin
                        o_fifo_wren <= 1'b1;
                        o_fifo_din  <= hdr[HDR_BITS-1 -: 8];
                        hdr         <= hdr << 8;
                        cnt         <= cnt + 1'b1;
                        if (cnt == CNT_W'(HDR_BYTES - 1))
                            state <= ST_BODY;
                    end
                end
                ST_BODY: begin
                    b_fifo_rden <= issue && !o_fifo_afull;
                    if (have && !o_fifo_afull) begin
                        hold_v      <= 1'b0;
                        o_fifo_wren <= 1'b1;
                        o_fifo_din  <= have_byte;
                        cnt         <= sat_inc(cnt);
                        if (have_del) begin
                            if (cnt_nx >= MINF) begin
                                o_fifo_del <= 1'b1;
                                frame_cnt  <= frame_cnt + 16'd1;
                                state      <= ST_IDLE;
                            end else begin
                                state <= ST_PAD;
                            end
                        end
                    end else if (b_dv) begin
                        // Egress is full: park the returned byte, never lose it.
                        hold_v   <= 1'b1;
                        hold     <= b_fifo_dout;
                        hold_del <= b_fifo_del;
                    end
                end
                ST_PAD: begin
                    if (!o_fifo_afull) begin
                        o_fifo_wren <= 1'b1;
                        o_fifo_din  <= 8'h00;
                        cnt         <= cnt + 1'b1;
                        if (cnt_nx >= MINF) begin
                            o_fifo_del <= 1'b1;
                            frame_cnt  <= frame_cnt + 16'd1;
                            state      <= ST_IDLE;
                        end
                    end
                end
                ST_DROP: begin
                    b_fifo_rden <= issue;
                    if (b_dv && b_fifo_del) begin
                        drop_cnt <= drop_cnt + 16'd1;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_frame_enc.sv
// Randomized self-checking bench for mac_frame_enc against a frame-level model.
// FIFOs are modelled with queues; expected egress bytes are built per frame.
module tb_mac_frame_enc;

    localparam int MIN_F = 60;
    localparam logic [3:0] PID = 4'd0;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] h_fifo_dout;
    logic         h_fifo_empty;
    logic         h_fifo_rden;
    logic [7:0]   b_fifo_dout;
    logic         b_fifo_del;
    logic         b_fifo_empty;
    logic         b_fifo_rden;
    logic [7:0]   o_fifo_din;
    logic         o_fifo_wren;
    logic         o_fifo_del;
    logic         o_fifo_afull;
    logic [15:0]  frame_cnt;
    logic [15:0]  drop_cnt;

    always #5 clk = ~clk;

    mac_frame_enc dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .h_fifo_dout  (h_fifo_dout),
        .h_fifo_empty (h_fifo_empty),
        .h_fifo_rden  (h_fifo_rden),
        .b_fifo_dout  (b_fifo_dout),
        .b_fifo_del   (b_fifo_del),
        .b_fifo_empty (b_fifo_empty),
        .b_fifo_rden  (b_fifo_rden),
        .o_fifo_din   (o_fifo_din),
        .o_fifo_wren  (o_fifo_wren),
        .o_fifo_del   (o_fifo_del),
        .o_fifo_afull (o_fifo_afull),
        .frame_cnt    (frame_cnt),
        .drop_cnt     (drop_cnt)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [127:0] hq[$];
    logic [8:0]   bq[$];
    logic [8:0]   pend[$];
    logic [8:0]   expq[$];
    logic [8:0]   wlog[$];

    int  frames_m = 0;
    int  drops_m = 0;
    int  hpops = 0;
    int  eod_popped = 0;
    int  bpops = 0;
    int  wr_total = 0;
    int  afull_mode = 0;
    int  cyc = 0;
    bit  run_chk = 1'b0;
    logic afull_q = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] getw(input int i);
        if (i < wlog.size()) return wlog[i];
        return 9'h1FF;
    endfunction

    // Upstream FIFOs: data appears the cycle after a pop.
    always @(posedge clk) begin
        logic [8:0] item;
        afull_q <= o_fifo_afull;
        if (h_fifo_rden === 1'b1) begin
            chk("h_pop_nonempty", 64'(hq.size() != 0), 64'd1);
            if (hq.size() != 0) begin
                h_fifo_dout <= hq.pop_front();
                hpops++;
            end
        end
        h_fifo_empty <= (hq.size() == 0);
        if (b_fifo_rden === 1'b1) begin
            chk("b_pop_nonempty", 64'(bq.size() != 0), 64'd1);
            if (bq.size() != 0) begin
                item = bq.pop_front();
                b_fifo_dout <= item[7:0];
                b_fifo_del  <= item[8];
                bpops++;
                if (item[8]) eod_popped++;
            end
        end
        b_fifo_empty <= (bq.size() == 0);
    end

    always @(negedge clk) begin
        logic [8:0] e;
        if (run_chk && rst_n === 1'b1) begin
            if (h_fifo_rden === 1'b1)
                chk("hdr_after_eod", 64'(hpops), 64'(eod_popped));
            if (o_fifo_wren === 1'b1) begin
                wr_total++;
                wlog.push_back({o_fifo_del, o_fifo_din});
                chk("afull_gate", 64'(afull_q), 64'd0);
                if (expq.size() == 0) begin
                    chk("unexpected_write", 64'd1, 64'd0);
                end else begin
                    e = expq.pop_front();
                    chk("out_byte", 64'({o_fifo_del, o_fifo_din}), 64'(e));
                    if (e[8]) frames_m++;
                end
            end else if (o_fifo_del !== 1'b0) begin
                chk("del_without_wren", 64'(o_fifo_del), 64'd0);
            end
            chk("frame_cnt", 64'(frame_cnt), 64'(16'(frames_m)));
        end
    end

    initial begin
        o_fifo_afull = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (afull_mode)
                1: if (cyc % 3 == 0) o_fifo_afull = ~o_fifo_afull;
                2: o_fifo_afull = ($urandom_range(0, 3) == 0);
                default: o_fifo_afull = 1'b0;
            endcase
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_frame(input logic [3:0] src, input int len,
                              input bit rnd, input int keep);
        logic [7:0]   hb[14];
        logic [127:0] w;
        logic [8:0]   body[$];
        logic [8:0]   e;
        logic [7:0]   b;
        int           n;
        w = '0;
        for (int i = 0; i < 14; i++) begin
            hb[i] = rnd ? 8'($urandom) : 8'(192 + i);
            w[127-8*i -: 8] = hb[i];
        end
        w[15:12] = src;
        w[11:0]  = rnd ? 12'($urandom) : 12'd0;
        hq.push_back(w);
        for (int i = 0; i < len; i++) begin
            b = rnd ? 8'($urandom) : 8'(i + 1);
            body.push_back({(i == len - 1), b});
        end
        for (int i = 0; i < len; i++) begin
            if (i < keep && pend.size() == 0) bq.push_back(body[i]);
            else pend.push_back(body[i]);
        end
        if (src == PID) begin
            drops_m++;
        end else begin
            for (int i = 0; i < 14; i++) expq.push_back({1'b0, hb[i]});
            for (int i = 0; i < len; i++) expq.push_back({1'b0, body[i][7:0]});
            n = 14 + len;
            while (n < MIN_F) begin
                expq.push_back(9'h000);
                n++;
            end
            e = expq.pop_back();
            expq.push_back({1'b1, e[7:0]});
        end
    endtask

    task automatic release_pend();
        while (pend.size() != 0) bq.push_back(pend.pop_front());
    endtask

    task automatic wait_idle(input string name, input int budget);
        int c = 0;
        while ((expq.size() != 0 || hq.size() != 0 || bq.size() != 0 ||
                pend.size() != 0) && c < budget) begin
            tick(1);
            c++;
        end
        chk(name, 64'(c < budget), 64'd1);
        tick(8);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_h_rden"}, 64'(h_fifo_rden), 64'd0);
        chk({tag, "_b_rden"}, 64'(b_fifo_rden), 64'd0);
        chk({tag, "_din"},    64'(o_fifo_din),  64'd0);
        chk({tag, "_wren"},   64'(o_fifo_wren), 64'd0);
        chk({tag, "_del"},    64'(o_fifo_del),  64'd0);
        chk({tag, "_fcnt"},   64'(frame_cnt),   64'd0);
        chk({tag, "_dcnt"},   64'(drop_cnt),    64'd0);
    endtask

    initial begin
        int w0;
        int b0;
        int c;
        int len;
        int sp;
        int dels;
        rst_n = 1'b0;
        tick(4);
        check_zero("reset");
        rst_n = 1'b1;
        run_chk = 1'b1;

        wlog.delete();
        push_frame(4'd1, 46, 1'b0, 46);
        wait_idle("t1_idle", 2000);
        chk("t1_writes", 64'(wlog.size()), 64'd60);
        chk("t1_hdr0",   64'(getw(0)),  64'h0C0);
        chk("t1_hdr13",  64'(getw(13)), 64'h0CD);
        chk("t1_body0",  64'(getw(14)), 64'h001);
        chk("t1_b58",    64'(getw(58)), 64'h02D);
        chk("t1_last",   64'(getw(59)), 64'h12E);
        chk("t1_fcnt",   64'(frame_cnt), 64'd1);

        wlog.delete();
        push_frame(4'd2, 10, 1'b0, 10);
        wait_idle("t2_idle", 2000);
        chk("t2_writes", 64'(wlog.size()), 64'd60);
        chk("t2_body9",  64'(getw(23)), 64'h00A);
        chk("t2_pad0",   64'(getw(24)), 64'h000);
        chk("t2_last",   64'(getw(59)), 64'h100);
        dels = 0;
        foreach (wlog[i]) if (wlog[i][8]) dels++;
        chk("t2_dels",   64'(dels), 64'd1);

        wlog.delete();
        b0 = bpops;
        push_frame(PID, 100, 1'b1, 100);
        wait_idle("t3_idle", 2000);
        chk("t3_pops",   64'(bpops - b0), 64'd100);
        chk("t3_writes", 64'(wlog.size()), 64'd0);
        chk("t3_dcnt",   64'(drop_cnt), 64'd1);
        push_frame(4'd3, 20, 1'b1, 20);
        wait_idle("t3b_idle", 2000);
        chk("t3b_writes", 64'(wlog.size()), 64'd60);
        chk("t3b_fcnt",   64'(frame_cnt), 64'd3);

        wlog.delete();
        afull_mode = 1;
        push_frame(4'd1, 1500, 1'b0, 1500);
        wait_idle("t4_idle", 20000);
        afull_mode = 0;
        chk("t4_writes", 64'(wlog.size()), 64'd1514);
        chk("t4_last",   64'(getw(1513)), 64'h1DC);

        w0 = wr_total;
        push_frame(4'd2, 100, 1'b0, 100);
        c = 0;
        while (wr_total - w0 < 30 && c < 2000) begin
            tick(1);
            c++;
        end
        chk("t5_reach_body", 64'(c < 2000), 64'd1);
        rst_n = 1'b0;
        tick(1);
        expq.delete();
        hq.delete();
        bq.delete();
        pend.delete();
        frames_m = 0;
        drops_m = 0;
        hpops = 0;
        eod_popped = 0;
        check_zero("t5");
        rst_n = 1'b1;
        tick(3);
        push_frame(4'd1, 5, 1'b1, 5);
        wait_idle("t5_idle", 2000);
        chk("t5_fcnt", 64'(frame_cnt), 64'd1);

        w0 = wr_total;
        push_frame(4'd1, 30, 1'b0, 10);
        push_frame(4'd2, 20, 1'b0, 20);
        tick(70);
        chk("t6_hpops",  64'(hpops), 64'd2);
        chk("t6_writes", 64'(wr_total - w0), 64'd24);
        release_pend();
        wait_idle("t6_idle", 3000);
        chk("t6_fcnt", 64'(frame_cnt), 64'd3);

        afull_mode = 2;
        for (int f = 0; f < 30; f++) begin
            len = $urandom_range(1, 120);
            sp = $urandom_range(1, len);
            push_frame(4'($urandom_range(0, 3)), len, 1'b1, sp);
            tick($urandom_range(0, 30));
            release_pend();
        end
        wait_idle("t7_idle", 40000);
        afull_mode = 0;
        chk("t7_dcnt", 64'(drop_cnt), 64'(16'(drops_m)));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #900000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
